// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT host register bridge: command bit
// positions, bus function codes, address windows, status bit positions and
// the engine sequencing state type.
package present_pkg;

  // Command bits, taken from Data_ib when Addr_ib selects the command function
  localparam int CMD_W     = 4;
  localparam int CMD_LATCH = 0;
  localparam int CMD_READ  = 1;
  localparam int CMD_WRITE = 2;
  localparam int CMD_START = 3;

  // Addr_ib bus functions
  localparam logic [1:0] FN_NOP   = 2'b00;
  localparam logic [1:0] FN_CMD   = 2'b01;
  localparam logic [1:0] FN_SHIFT = 2'b10;
  localparam logic [1:0] FN_CLEAR = 2'b11;

  // Register windows
  localparam int PT_BASE  = 'h00;
  localparam int KEY_BASE = 'h10;

  // Status word bit positions
  localparam int ST_READY = 0;
  localparam int ST_BUSY  = 1;
  localparam int ST_DONE  = 2;
  localparam int ST_ERR   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } seq_state_e;

endpackage

// File: rtl/present_seq_fsm.sv
// Engine sequencer: start/Ready handshake with the serial PRESENT core,
// one-cycle Start_o pulse, busy and sticky done, start-error pulse and the
// capture strobe for the result buffer.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | engine idle; a start with Ready_i=1 is accepted
//   LAUNCH | Start_o high for this one cycle; engine drops Ready meanwhile
//   RUN    | waiting for Ready_i=1, then capture ciphertext and flag done
module present_seq_fsm
  import present_pkg::*;
(
  input  logic Clk_ik,
  input  logic Reset_ir,
  input  logic Start_i,
  input  logic Ready_i,
  input  logic DoneClr_i,
  output logic Start_o,
  output logic Busy_o,
  output logic Done_o,
  output logic StartErr_o,
  output logic Capture_o
);

  seq_state_e state_q, state_d;
  logic       done_d;

  // State and sticky done registers
  always_ff @(posedge Clk_ik or posedge Reset_ir) begin
    if (Reset_ir) begin
      state_q <= IDLE;
      Done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      Done_o  <= done_d;
    end
  end

  // Next state, done update, error and capture strobes
  always_comb begin
    state_d    = state_q;
    done_d     = Done_o;
    StartErr_o = 1'b0;
    Capture_o  = 1'b0;
    if (DoneClr_i) done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start_i) begin
          if (Ready_i) begin
            state_d = LAUNCH;
            done_d  = 1'b0;
          end else begin
            StartErr_o = 1'b1;
          end
        end
      end
      LAUNCH: begin
        state_d = RUN;
        if (Start_i) StartErr_o = 1'b1;
      end
      RUN: begin
        if (Start_i) StartErr_o = 1'b1;
        if (Ready_i) begin
          Capture_o = 1'b1;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The pulse is exactly the LAUNCH cycle, so it cannot stretch or repeat
  assign Start_o = (state_q == LAUNCH);
  assign Busy_o  = (state_q != IDLE);

endmodule

// File: rtl/present_reg_bridge.sv
// Host register bridge for the serial PRESENT engine. A narrow multiplexed
// pin bus builds bytes in InputData, commands latch an address, read the
// captured result, write plaintext/key bytes or launch the engine.
// Optional build macro: PRESENT_AUTOINC_EN (read/write commands post-increment
// the register address; a latch in the same command takes priority).
module present_reg_bridge
  import present_pkg::*;
#(
  parameter int BUS_W = 4,
  parameter int REG_W = 8,
  parameter int BLK_W = 64,
  parameter int KEY_W = 80
) (
  input  logic             Clk_ik,
  input  logic             Reset_ir,
  input  logic [1:0]       Addr_ib,
  input  logic [BUS_W-1:0] Data_ib,
  output logic [REG_W-1:0] Data_ob,
  output logic [BLK_W-1:0] PlainText_ob,
  output logic [KEY_W-1:0] Key_ob,
  input  logic [BLK_W-1:0] CipherText_ib,
  output logic             Start_o,
  input  logic             Ready_i
);

  localparam int NPT  = BLK_W / REG_W;
  localparam int NKEY = KEY_W / REG_W;
  localparam logic [REG_W-1:0] PT_HI  = REG_W'(PT_BASE + NPT - 1);
  localparam logic [REG_W-1:0] KEY_LO = REG_W'(KEY_BASE);
  localparam logic [REG_W-1:0] KEY_HI = REG_W'(KEY_BASE + NKEY - 1);

  logic [REG_W-1:0] input_q;
  logic [CMD_W-1:0] cmd_q;
  logic [REG_W-1:0] reg_addr_q;
  logic [REG_W-1:0] out_q;
  logic [BLK_W-1:0] result_q;
  logic             err_q;

  logic             do_latch, do_rd, do_wr, do_start;
  logic             is_pt, is_key, wr_ok, err_src, done_clr;
  logic             busy, done, start_err, capture;
  logic [REG_W-1:0] rd_data;
  logic [REG_W-1:0] status;

  assign do_latch = cmd_q[CMD_LATCH];
  assign do_rd    = cmd_q[CMD_READ];
  assign do_wr    = cmd_q[CMD_WRITE];
  assign do_start = cmd_q[CMD_START];

  // Plaintext window begins at address zero, so only the top bound is checked
  assign is_pt    = (reg_addr_q <= PT_HI);
  assign is_key   = (reg_addr_q >= KEY_LO) && (reg_addr_q <= KEY_HI);
  assign wr_ok    = do_wr && (is_pt || is_key) && !busy;
  assign done_clr = do_rd && (reg_addr_q == REG_W'(PT_BASE));

  assign err_src  = (do_rd && !is_pt)
                  || (do_wr && !is_pt && !is_key)
                  || (do_wr && (is_pt || is_key) && busy)
                  || start_err;

  present_seq_fsm u_seq (
    .Clk_ik     (Clk_ik),
    .Reset_ir   (Reset_ir),
    .Start_i    (do_start),
    .Ready_i    (Ready_i),
    .DoneClr_i  (done_clr),
    .Start_o    (Start_o),
    .Busy_o     (busy),
    .Done_o     (done),
    .StartErr_o (start_err),
    .Capture_o  (capture)
  );

  // Result-buffer byte selected by the current address; zero outside the window
  always_comb begin
    rd_data = '0;
    for (int n = 0; n < NPT; n++) begin
      if (reg_addr_q == REG_W'(PT_BASE + n)) rd_data = result_q[n*REG_W +: REG_W];
    end
  end

  // Status word as seen on the read bus
  always_comb begin
    status           = '0;
    status[ST_READY] = Ready_i;
    status[ST_BUSY]  = busy;
    status[ST_DONE]  = done;
    status[ST_ERR]   = err_q;
  end

  // Pin bus front end: byte assembly and single-cycle command capture
  always_ff @(posedge Clk_ik or posedge Reset_ir) begin
    if (Reset_ir) begin
      input_q <= '0;
      cmd_q   <= '0;
    end else begin
      cmd_q <= (Addr_ib == FN_CMD) ? CMD_W'(Data_ib) : '0;
      case (Addr_ib)
        FN_SHIFT: input_q <= (input_q << BUS_W) | REG_W'(Data_ib);
        FN_CLEAR: input_q <= '0;
        FN_NOP, FN_CMD: input_q <= input_q;
        default:  input_q <= input_q;
      endcase
    end
  end

  // Register address: latch always wins; optional post-increment on access
  always_ff @(posedge Clk_ik or posedge Reset_ir) begin
    if (Reset_ir) begin
      reg_addr_q <= '0;
    end else if (do_latch) begin
      reg_addr_q <= input_q;
    end
`ifdef PRESENT_AUTOINC_EN
    else if (do_rd || do_wr) begin
      reg_addr_q <= reg_addr_q + 1'b1;
    end
`else
    else begin
      reg_addr_q <= reg_addr_q;
    end
`endif
  end

  // Plaintext and key byte writes, only while the engine is idle
  always_ff @(posedge Clk_ik or posedge Reset_ir) begin
    if (Reset_ir) begin
      PlainText_ob <= '0;
      Key_ob       <= '0;
    end else if (wr_ok) begin
      for (int n = 0; n < NPT; n++) begin
        if (reg_addr_q == REG_W'(PT_BASE + n)) PlainText_ob[n*REG_W +: REG_W] <= input_q;
      end
      for (int n = 0; n < NKEY; n++) begin
        if (reg_addr_q == REG_W'(KEY_BASE + n)) Key_ob[n*REG_W +: REG_W] <= input_q;
      end
    end
  end

  // Read data, captured result and sticky error (new error beats latch-clear)
  always_ff @(posedge Clk_ik or posedge Reset_ir) begin
    if (Reset_ir) begin
      out_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (do_rd)   out_q    <= rd_data;
      if (capture) result_q <= CipherText_ib;
      if (err_src)       err_q <= 1'b1;
      else if (do_latch) err_q <= 1'b0;
    end
  end

  // Registered read bus
  always_ff @(posedge Clk_ik or posedge Reset_ir) begin
    if (Reset_ir) Data_ob <= '0;
    else          Data_ob <= Addr_ib[1] ? out_q : status;
  end

endmodule

// File: doc/present_reg_bridge.md
Name: present_reg_bridge

Overview:
- Parametrised host-side register bridge for the serial PRESENT engine: narrow multiplexed pin bus in, wide plaintext/key/ciphertext registers out.
- Successor of the fixed 4-bit/8-bit top-level interface. Adds generic bus/register/key widths, an engine sequencing FSM, a captured result buffer, and sticky done/error status.
- Sits between the chip pins and core_serial. The top level becomes pin mapping plus an instance of this block and the engine.

Parameters:
- BUS_W, 4, input data pins per transfer; must divide REG_W.
- REG_W, 8, register/byte width and Data_ob width.
- BLK_W, 64, cipher block width; multiple of REG_W.
- KEY_W, 80, key width (80 or 128); multiple of REG_W.

Ports:
- Clk_ik  in  1  single clock, all logic on rising edge.
- Reset_ir  in  1  asynchronous, active-high reset.
- Addr_ib  in  2  bus function select.
- Data_ib  in  BUS_W  bus write data.
- Data_ob  out  REG_W  registered bus read data.
- PlainText_ob  out  BLK_W  to engine.
- Key_ob  out  KEY_W  to engine.
- CipherText_ib  in  BLK_W  from engine.
- Start_o  out  1  one-cycle start pulse to engine.
- Ready_i  in  1  engine idle/finished flag.

Behaviour:
- Reset: every register, including Data_ob, Start_o, PlainText_ob, Key_ob, the result buffer, address and status bits, goes to 0. FSM goes to IDLE. Reset asserted mid-run abandons the run; no done is flagged.
- Addr_ib function:
  - 00: no write.
  - 01: load command, self-clearing after one cycle.
  - 10: shift InputData MSB-first, InputData <= {InputData[REG_W-BUS_W-1:0], Data_ib}.
  - 11: clear InputData to 0.
- Data_ob is registered, one cycle latency. Addr_ib[1]=0 returns Status; Addr_ib[1]=1 returns OutputData.
- Command bits: 0 = latch address (RegAddr <= InputData, also clears err); 1 = read; 2 = write; 3 = start.
  - All set bits act in the same cycle, one cycle after the 01 write.
  - Read and write use the pre-update RegAddr.
  - Latch overrides auto-increment.
  - Read and write in the same command: the read returns the old contents.
- Address map:
  - 0x00..BLK_W/REG_W-1: write sets plaintext byte n; read returns result-buffer byte n.
  - 0x10..0x10+KEY_W/REG_W-1: key byte n, write-only. A read here returns 0 and sets err.
  - Any other address: write ignored, read gives OutputData=0, err set.
  - A plaintext/key write while FSM≠IDLE is ignored and sets err.
- Status = {0..., err, done, busy, Ready_i}, bits 3..0.
- FSM:
  - IDLE: on start with Ready_i=1, pulse Start_o for one cycle, clear done, go to LAUNCH. Start with Ready_i=0 sets err, no pulse.
  - LAUNCH: wait exactly one cycle (engine drops Ready), then go to RUN.
  - RUN: on Ready_i=1, capture CipherText_ib into the result buffer, set done, go to IDLE.
  - Start in LAUNCH or RUN: ignored, err set.
  - busy = (FSM≠IDLE).
- done is sticky. It is cleared by the next accepted start or by a read of address 0x00.
- err is sticky. It is cleared only by a latch-address command or reset; if latch and a new error source occur in the same cycle, err is set.
- Result buffer is stable between runs, independent of the engine's live output.

Optional Feature:
- PRESENT_AUTOINC_EN defined: each executed read or write command (valid or not) increments RegAddr by 1 mod 2^REG_W, wrapping 0xFF->0x00. Latch-address in the same command wins over the increment.
- Undefined: RegAddr changes only on latch-address.

Decomposition:
- Package present_pkg: command bit indices, Addr_ib function codes, PT_BASE=0x00, KEY_BASE=0x10, status bit indices, FSM state enum {IDLE, LAUNCH, RUN}.
- One sub-module, present_seq_fsm: start/Ready handshake, Start_o pulse, busy/done, start-error output. Address decode and register file stay in present_reg_bridge.

Test Plan:
- Reset with Data_ob pins 0xFF seen via Addr 00 -> Data_ob=0x01 once Ready_i=1; Start_o=0; all key/plaintext outputs 0.
- Load plaintext 0 and key 0 (80-bit) through nibble shifts and write commands, issue start -> one Start_o pulse, busy=1; after engine completes, done=1 and bytes 0x07..0x00 read 55 79 C1 38 7B 22 84 45.
- Reading address 0x00 clears done. Reading 0x12 -> OutputData=0x00, err=1. Latch-address command clears err.
- Start issued while RUN -> no second Start_o, err=1; result buffer unchanged. Plaintext write during RUN leaves PlainText_ob unchanged.
- With PRESENT_AUTOINC_EN: latch 0x10, then write 10 consecutive key bytes -> Key_ob = concatenation in order, RegAddr=0x1A. Without the macro: all 10 writes land in byte 0x10.
- Assert Reset_ir during RUN -> FSM IDLE, done=0, busy=0 immediately (asynchronous), Start_o stays 0.
